lcd_ctrl: RTL and testbench
===========================

// Module: lcd_ctrl
// PURPOSE
//  Downstream consumer of the LSU LCD register (o_io_lcd). Turns 32-bit software command words into
//  HD44780 bus cycles (RS/RW/EN/DATA) with correct setup, pulse, hold and execution timing.
//  Also runs the power-up init sequence and reports busy/ack so firmware can pace its writes.
// PARAMETERS
//  CLK_FREQ_HZ   50_000_000  i_clk frequency; all delays derive from it
//  T_PWRUP_US    15_000      wait after reset before the init sequence starts
//  T_SETUP_CYC   4           RS/DATA-valid to EN-rise, in cycles (min 1)
//  T_EN_CYC      25          EN high width, in cycles (min 1)
//  T_HOLD_CYC    4           EN-fall to DATA/RS change, in cycles (min 1)
//  T_EXEC_US     40          command execution wait, normal commands
//  T_LONG_US     1_640       execution wait for clear/home (RS=0, data 8'h01..8'h03)
// PORTS
//  i_clk          in   1   system clock
//  i_reset        in   1   asynchronous, active-low reset
//  i_io_lcd       in   32  LSU o_io_lcd: [31] ON, [30] REQ toggle, [29] BLON, [8] RS, [7:0] DATA
//  o_lcd_data     out  8   LCD data bus
//  o_lcd_rs       out  1   register select
//  o_lcd_rw       out  1   read/write; tied 0 (write only)
//  o_lcd_en       out  1   enable strobe
//  o_lcd_on       out  1   panel power, follows i_io_lcd[31]
//  o_lcd_blon     out  1   backlight, follows i_io_lcd[29]
//  o_lcd_status   out  32  [31] busy, [30] ack toggle, [29] init_done, [28:0] 0; feeds load-path mux
// BEHAVIOUR
//  Reset (async, i_reset=0): every output 0, state S_PWRUP, timer loaded with T_PWRUP cycles,
//   ack toggle 0, init index 0. EN drops to 0 asynchronously, even mid-pulse.
//  o_lcd_on/o_lcd_blon: register i_io_lcd bits every cycle (1-cycle latency), independent of the FSM.
//  Request rule: a request is pending when i_io_lcd[30] != ack toggle, sampled only in S_IDLE.
//   On accept, capture RS/DATA, set busy, go to S_SETUP. Ack toggle flips when S_EXEC ends.
//   Two flips while busy cancel each other (no request); firmware polls busy before writing.
//  FSM:
//   S_PWRUP: count T_PWRUP; on expiry -> S_SETUP with init word 0.
//   S_SETUP: drive RS/DATA, EN=0, count T_SETUP_CYC -> S_EN_HI.
//   S_EN_HI: EN=1 for exactly T_EN_CYC cycles -> S_HOLD.
//   S_HOLD: EN=0, RS/DATA held T_HOLD_CYC -> S_EXEC.
//   S_EXEC: wait T_LONG if RS=0 and DATA in 1..3, else T_EXEC; then
//    if init not done: index++; next init word -> S_SETUP, or after the last word set init_done -> S_IDLE;
//    otherwise flip ack, clear busy -> S_IDLE.
//   S_IDLE: busy=0; a pending request -> S_SETUP next cycle.
//  Init ROM, RS=0: 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06. Busy=1 throughout; software requests stay pending.
//  Request to first EN rise: 1 + T_SETUP_CYC cycles. Total busy = 1 + SETUP + EN + HOLD + exec cycles.
//  Timer: one down-counter, width = clog2(max cycle count)+1; loading 0 is forbidden (min 1 enforced).
//  RS/DATA change only on S_SETUP entry; they are stable in S_EN_HI and S_HOLD.
//  A request present at reset release is ignored until init_done. Ack resets to 0, so firmware
//   must reset its toggle shadow together with i_reset.
// STRUCTURE
//  Package lcd_pkg: state enum (S_PWRUP, S_SETUP, S_EN_HI, S_HOLD, S_EXEC, S_IDLE), init ROM
//   constant array, LCD bit-field index localparams, function us_to_cyc(us, clk_hz).
//  Sub-module lcd_timer: load/value/expired down-counter; lcd_ctrl is the FSM plus capture registers.
// TESTING (sim with CLK_FREQ_HZ=1_000_000 so 1 us = 1 cycle; T_PWRUP_US=20)
//  Reset release -> 20 idle cycles, then 6 EN pulses with DATA 38,38,38,0C,01,06; the gap after 01 is long;
//   init_done=1, busy=0.
//  After init, i_io_lcd=32'h4000_0141 -> RS=1, DATA=8'h41; EN high 25 cycles; busy low after SETUP+EN+HOLD+40+1;
//   status[30]=1.
//  i_io_lcd=32'h0000_0001 (toggle back, clear) -> RS=0, DATA=01; exec wait 1640 cycles.
//  Toggle bit 30 twice while busy -> no second EN pulse; ack unchanged.
//  Assert i_reset during S_EN_HI -> o_lcd_en=0 in the same cycle; outputs 0; init re-runs after release.
//  Request issued during init -> held pending, executes right after init_done; RS/DATA stable while EN=1 (assertion).

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the HD44780 bus controller.
//   lcd_state_t  - controller FSM states
//   lcd_cmd_t    - one bus command (register select + data byte)
//   INIT_ROM     - power-up command sequence, entry 0 sent first
//   *_BIT        - field positions in the LSU command word and status word
//   us_to_cyc    - microseconds to clock cycles (rounded up, never 0)
package lcd_pkg;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_SETUP,
        S_EN_HI,
        S_HOLD,
        S_EXEC,
        S_IDLE
    } lcd_state_t;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_cmd_t;

    // Command word fields (i_io_lcd)
    localparam int LCD_ON_BIT   = 31;
    localparam int LCD_REQ_BIT  = 30;
    localparam int LCD_BLON_BIT = 29;
    localparam int LCD_RS_BIT   = 8;

    // Status word fields (o_lcd_status)
    localparam int STAT_BUSY_BIT = 31;
    localparam int STAT_ACK_BIT  = 30;
    localparam int STAT_INIT_BIT = 29;

    // Init sequence: function set x3, display on, clear, entry mode.
    localparam int INIT_LEN = 6;
    localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {
        8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38
    };
    localparam logic [2:0] INIT_LAST = 3'(INIT_LEN - 1);

    // Rounded up so a delay is never shorter than asked; a zero result
    // would stall the down-counter, so it is clamped to one cycle.
    function automatic int unsigned us_to_cyc(input int unsigned us,
                                              input int unsigned clk_hz);
        logic [63:0] cyc;
        cyc = (64'(us) * 64'(clk_hz) + 64'd999_999) / 64'd1_000_000;
        return (cyc == 64'd0) ? 32'd1 : cyc[31:0];
    endfunction

    function automatic int unsigned min1(input int unsigned c);
        return (c == 0) ? 32'd1 : c;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// lcd_timer: single down-counter that times every FSM phase.
//   i_clk, i_reset (async, active low)
//   i_load     - load i_value this cycle (0 is promoted to 1)
//   i_value    - phase length in cycles
//   o_expired  - last cycle of the current phase
// A phase loaded with N lasts exactly N cycles: the count runs N..1 and
// the owner moves on at the edge where the count is 1.
module lcd_timer #(
    parameter int           W         = 8,
    parameter logic [W-1:0] RESET_VAL = W'(1)
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt <= RESET_VAL;
        end else if (i_load) begin
            cnt <= (i_value == '0) ? W'(1) : i_value;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign o_expired = (cnt == W'(1));

endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: turns LSU command words into HD44780 write cycles, runs the
// power-up init sequence and reports busy/ack/init_done to firmware.
//   i_clk, i_reset    - clock, async active-low reset
//   i_io_lcd[31:0]    - [31] ON, [30] REQ toggle, [29] BLON, [8] RS, [7:0] DATA
//   o_lcd_data[7:0]   - LCD data bus
//   o_lcd_rs/rw/en    - register select, read/write (always write), enable
//   o_lcd_on/blon     - panel power / backlight, registered copies of the word
//   o_lcd_status[31:0]- [31] busy, [30] ack toggle, [29] init_done
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned T_PWRUP_US  = 15_000,
    parameter int unsigned T_SETUP_CYC = 4,
    parameter int unsigned T_EN_CYC    = 25,
    parameter int unsigned T_HOLD_CYC  = 4,
    parameter int unsigned T_EXEC_US   = 40,
    parameter int unsigned T_LONG_US   = 1_640
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_io_lcd,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_lcd_blon,
    output logic [31:0] o_lcd_status
);

    localparam int unsigned PWRUP_CYC = us_to_cyc(T_PWRUP_US, CLK_FREQ_HZ);
    localparam int unsigned SETUP_CYC = min1(T_SETUP_CYC);
    localparam int unsigned EN_CYC    = min1(T_EN_CYC);
    localparam int unsigned HOLD_CYC  = min1(T_HOLD_CYC);
    localparam int unsigned EXEC_CYC  = us_to_cyc(T_EXEC_US, CLK_FREQ_HZ);
    localparam int unsigned LONG_CYC  = us_to_cyc(T_LONG_US, CLK_FREQ_HZ);
    localparam int unsigned MAX_CYC   = max2(max2(max2(PWRUP_CYC, SETUP_CYC),
                                                  max2(EN_CYC, HOLD_CYC)),
                                             max2(EXEC_CYC, LONG_CYC));
    localparam int          TW        = $clog2(MAX_CYC) + 1;

    lcd_state_t state_q, state_d;
    lcd_cmd_t   cmd_q, cmd_d;
    logic [2:0] idx_q, idx_d;
    logic       ack_q, ack_d;
    logic       init_done_q, init_done_d;
    logic       busy_q, en_q, on_q, blon_q;

    logic          tmr_load;
    logic [TW-1:0] tmr_value;
    logic          tmr_expired;

    logic     req_pending;
    lcd_cmd_t req_cmd;
    logic     long_exec;
    logic     unused_io;

    // Only IDLE looks at the toggle, so flips while busy are deferred,
    // and an even number of them simply vanishes.
    assign req_pending  = (i_io_lcd[LCD_REQ_BIT] != ack_q);
    assign req_cmd.rs   = i_io_lcd[LCD_RS_BIT];
    assign req_cmd.data = i_io_lcd[7:0];
    assign unused_io    = ^i_io_lcd[28:9];

    // Clear display / return home need the long execution wait.
    assign long_exec = !cmd_q.rs && (cmd_q.data >= 8'd1) && (cmd_q.data <= 8'd3);

    lcd_timer #(
        .W         (TW),
        .RESET_VAL (TW'(PWRUP_CYC))
    ) u_timer (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_load    (tmr_load),
        .i_value   (tmr_value),
        .o_expired (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        idx_d       = idx_q;
        ack_d       = ack_q;
        init_done_d = init_done_q;
        tmr_load    = 1'b0;
        tmr_value   = TW'(SETUP_CYC);

        unique case (state_q)
            S_PWRUP: begin
                if (tmr_expired) begin
                    state_d    = S_SETUP;
                    idx_d      = 3'd0;
                    cmd_d.rs   = 1'b0;
                    cmd_d.data = INIT_ROM[0];
                    tmr_load   = 1'b1;
                    tmr_value  = TW'(SETUP_CYC);
                end
            end
            S_SETUP: begin
                if (tmr_expired) begin
                    state_d   = S_EN_HI;
                    tmr_load  = 1'b1;
                    tmr_value = TW'(EN_CYC);
                end
            end
            S_EN_HI: begin
                if (tmr_expired) begin
                    state_d   = S_HOLD;
                    tmr_load  = 1'b1;
                    tmr_value = TW'(HOLD_CYC);
                end
            end
            S_HOLD: begin
                if (tmr_expired) begin
                    state_d   = S_EXEC;
                    tmr_load  = 1'b1;
                    tmr_value = long_exec ? TW'(LONG_CYC) : TW'(EXEC_CYC);
                end
            end
            S_EXEC: begin
                if (tmr_expired) begin
                    if (!init_done_q) begin
                        if (idx_q == INIT_LAST) begin
                            init_done_d = 1'b1;
                            state_d     = S_IDLE;
                        end else begin
                            idx_d      = idx_q + 3'd1;
                            cmd_d.rs   = 1'b0;
                            cmd_d.data = INIT_ROM[idx_d];
                            state_d    = S_SETUP;
                            tmr_load   = 1'b1;
                            tmr_value  = TW'(SETUP_CYC);
                        end
                    end else begin
                        ack_d   = ~ack_q;
                        state_d = S_IDLE;
                    end
                end
            end
            S_IDLE: begin
                if (req_pending) begin
                    cmd_d     = req_cmd;
                    state_d   = S_SETUP;
                    tmr_load  = 1'b1;
                    tmr_value = TW'(SETUP_CYC);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so EN and busy line
    // up exactly with the state they describe; RS/DATA only move when a
    // new command is loaded on SETUP entry.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= S_PWRUP;
            cmd_q       <= '0;
            idx_q       <= 3'd0;
            ack_q       <= 1'b0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b0;
            en_q        <= 1'b0;
            on_q        <= 1'b0;
            blon_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            idx_q       <= idx_d;
            ack_q       <= ack_d;
            init_done_q <= init_done_d;
            busy_q      <= (state_d != S_IDLE);
            en_q        <= (state_d == S_EN_HI);
            on_q        <= i_io_lcd[LCD_ON_BIT];
            blon_q      <= i_io_lcd[LCD_BLON_BIT];
        end
    end

    assign o_lcd_data = cmd_q.data;
    assign o_lcd_rs   = cmd_q.rs;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = en_q;
    assign o_lcd_on   = on_q;
    assign o_lcd_blon = blon_q;

    always_comb begin
        o_lcd_status                = '0;
        o_lcd_status[STAT_BUSY_BIT] = busy_q;
        o_lcd_status[STAT_ACK_BIT]  = ack_q;
        o_lcd_status[STAT_INIT_BIT] = init_done_q;
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: drives lcd_ctrl at 1 MHz (1 us = 1 cycle) with directed and
// random command words; a timeline model predicts every output each cycle.
`timescale 1ns/1ps
module tb_lcd_ctrl;

    localparam int S = 4, E = 25, H = 4, XN = 40, XL = 1640, PW = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] io = 32'h0;
    logic [7:0]  o_lcd_data;
    logic        o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_lcd_blon;
    logic [31:0] o_lcd_status;

    lcd_ctrl #(
        .CLK_FREQ_HZ (1_000_000), .T_PWRUP_US (PW), .T_SETUP_CYC (S),
        .T_EN_CYC (E), .T_HOLD_CYC (H), .T_EXEC_US (XN), .T_LONG_US (XL)
    ) dut (
        .i_clk (clk), .i_reset (rst_n), .i_io_lcd (io),
        .o_lcd_data (o_lcd_data), .o_lcd_rs (o_lcd_rs), .o_lcd_rw (o_lcd_rw),
        .o_lcd_en (o_lcd_en), .o_lcd_on (o_lcd_on), .o_lcd_blon (o_lcd_blon),
        .o_lcd_status (o_lcd_status)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errs = 0;

    // ---------------- model: a job is one command on the bus ----------------
    typedef enum {M_PWR, M_JOB, M_IDLE} mph_t;
    mph_t       m_ph = M_PWR;
    int         m_t = 0, m_len = 0, m_idx = 0;
    bit         m_init = 0, m_busy = 0, m_ack = 0, m_done = 0;
    bit         m_rs = 0, m_en = 0, m_on = 0, m_blon = 0;
    logic [7:0] m_data = 8'h0;
    logic [7:0] rom [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    task automatic start_job(input bit rs, input logic [7:0] d, input bit init);
        m_ph = M_JOB; m_t = 0; m_rs = rs; m_data = d; m_init = init; m_busy = 1;
        m_len = S + E + H + ((!rs && d >= 8'd1 && d <= 8'd3) ? XL : XN);
    endtask

    task automatic model_step();
        if (!rst_n) begin
            m_ph = M_PWR; m_t = 0; m_idx = 0; m_init = 0; m_busy = 0; m_ack = 0;
            m_done = 0; m_rs = 0; m_en = 0; m_on = 0; m_blon = 0; m_data = 8'h0;
            return;
        end
        m_on = io[31];
        m_blon = io[29];
        case (m_ph)
            M_PWR: begin
                m_t++; m_busy = 1;
                if (m_t == PW) start_job(1'b0, rom[0], 1'b1);
            end
            M_JOB: begin
                m_t++;
                if (m_t == m_len) begin
                    if (m_init && m_idx < 5) begin
                        m_idx++;
                        start_job(1'b0, rom[m_idx], 1'b1);
                    end else begin
                        if (m_init) m_done = 1; else m_ack = ~m_ack;
                        m_ph = M_IDLE; m_busy = 0;
                    end
                end
            end
            default: if (io[30] != m_ack) start_job(io[8], io[7:0], 1'b0);
        endcase
        m_en = (m_ph == M_JOB) && (m_t >= S) && (m_t < S + E);
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    int         en_rises = 0;
    logic [7:0] rise_q[$];
    logic       prev_en = 1'b0;
    logic [8:0] prev_rsd = 9'h0;

    initial forever begin
        logic [44:0] exp_v, act_v;
        @(negedge clk);
        exp_v = {m_data, m_rs, 1'b0, m_en, m_on, m_blon, m_busy, m_ack, m_done, 29'd0};
        act_v = {o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_lcd_blon, o_lcd_status};
        vectors++;
        if (act_v !== exp_v) begin
            errs++;
            $display("FAIL cycle_cmp t=%0t actual=%h required=%h", $time, act_v, exp_v);
        end
        if (o_lcd_en && prev_en) begin
            vectors++;
            if ({o_lcd_rs, o_lcd_data} !== prev_rsd) begin
                errs++;
                $display("FAIL rsdata_stable_en t=%0t actual=%h required=%h",
                         $time, {o_lcd_rs, o_lcd_data}, prev_rsd);
            end
        end
        if (o_lcd_en && !prev_en) begin
            en_rises++;
            rise_q.push_back(o_lcd_data);
        end
        prev_en = o_lcd_en;
        prev_rsd = {o_lcd_rs, o_lcd_data};
    end

    // ---------------- helpers ----------------
    bit req = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        vectors++; errs++;
        $display("FAIL %s: timeout waiting on DUT", name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input bit rs, input logic [7:0] d);
        req = ~req; io[30] = req; io[8] = rs; io[7:0] = d;
    endtask

    task automatic flip_req();
        req = ~req; io[30] = req;
    endtask

    // Counts edges until busy is seen low at a negedge.
    task automatic wait_idle(input int maxc, input string name, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (o_lcd_status[31] && n < maxc);
        if (o_lcd_status[31]) timeout(name);
    endtask

    task automatic wait_en(input int maxc, input string name, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!o_lcd_en && n < maxc);
        if (!o_lcd_en) timeout(name);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n, w, tot, r0;
        logic [7:0] init_exp [6];
        init_exp = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

        tick(3);
        check("reset_status", o_lcd_status, 32'h0);
        check("reset_bus", {o_lcd_data, o_lcd_rs, o_lcd_en, o_lcd_on, o_lcd_blon}, 12'h0);

        // Power-up init: 20 + 6*(4+25+4) + 5*40 + 1640 edges until idle.
        rise_q.delete();
        #2 rst_n = 1'b1;
        wait_idle(4000, "init_idle", n);
        check("init_cycles", n, 2058);
        check("init_pulses", rise_q.size(), 6);
        for (int i = 0; i < 6 && i < rise_q.size(); i++)
            check($sformatf("init_word%0d", i), rise_q[i], init_exp[i]);
        check("init_status", o_lcd_status, 32'h2000_0000);

        // Data write 'A'
        send(1'b1, 8'h41);
        check("cmd_word", io, 32'h4000_0141);
        wait_en(20, "cmd1_en", n);
        check("cmd1_en_latency", n, 5);
        check("cmd1_rsdata", {o_lcd_rs, o_lcd_data}, 9'h141);
        w = 0;
        do begin w++; @(negedge clk); end while (o_lcd_en && w < 100);
        check("cmd1_en_width", w, 25);
        wait_idle(200, "cmd1_idle", tot);
        check("cmd1_busy_cycles", n + w + tot, 74);
        check("cmd1_status", o_lcd_status, 32'h6000_0000);

        // Clear display: long execution wait
        send(1'b0, 8'h01);
        check("clr_word", io, 32'h0000_0001);
        wait_idle(3000, "clr_idle", n);
        check("clr_busy_cycles", n, 1674);
        check("clr_rsdata", {o_lcd_rs, o_lcd_data}, 9'h001);
        check("clr_status", o_lcd_status, 32'h2000_0000);

        // Two toggles while busy cancel out
        r0 = en_rises;
        send(1'b1, 8'h55);
        tick(10); flip_req(); tick(3); flip_req();
        wait_idle(200, "dbl_idle", n);
        tick(60);
        check("dbl_pulses", en_rises - r0, 1);
        check("dbl_status", o_lcd_status, 32'h6000_0000);

        // Random traffic
        for (int k = 0; k < 30; k++) begin
            int gap;
            gap = $urandom_range(0, 4);
            for (int g = 0; g < gap; g++) begin
                io[31] = 1'($urandom); io[29] = 1'($urandom);
                tick(1);
            end
            send(1'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                tick($urandom_range(1, 30)); flip_req();
                tick($urandom_range(1, 3)); flip_req();
            end
            wait_idle(2000, "rand_idle", n);
        end

        // Reset in the middle of an EN pulse
        send(1'b0, 8'h80);
        wait_en(20, "rst_en", n);
        @(posedge clk); #2 rst_n = 1'b0;
        #1 check("rst_async_outputs",
                 {o_lcd_data, o_lcd_rs, o_lcd_en, o_lcd_on, o_lcd_blon, o_lcd_status}, 44'h0);
        req = 1'b0; io = 32'h0;
        tick(3);

        // Request raised during init waits for init_done
        r0 = en_rises;
        rise_q.delete();
        #2 rst_n = 1'b1;
        io[31] = 1'b1;
        send(1'b1, 8'h5A);
        wait_idle(4000, "reinit_idle", n);
        check("reinit_cycles", n, 2058);
        wait_idle(200, "pend_idle", n);
        check("pend_busy_cycles", n, 74);
        check("pend_pulses", en_rises - r0, 7);
        if (rise_q.size() == 7) check("pend_data", rise_q[6], 8'h5A);
        else timeout("pend_data");
        check("pend_status", o_lcd_status, 32'h6000_0000);
        check("pend_on", o_lcd_on, 1'b1);

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
